// File: rtl/alu_rs_sched.sv
// Reservation station for the integer ALU: buffers dispatched ops, snoops both CDBs
// for pending operands and issues the lowest-index ready op each cycle.
module alu_rs_sched #(
   parameter int RS_SIZE = 16,
   parameter int ROB_W   = 4,
   parameter int DATA_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              rollback,
   input  logic              disp_en,
   input  logic [6:0]        disp_opcode,
   input  logic [2:0]        disp_funct3,
   input  logic              disp_funct7,
   input  logic [DATA_W-1:0] disp_val1,
   input  logic              disp_q1_busy,
   input  logic [ROB_W-1:0]  disp_q1,
   input  logic [DATA_W-1:0] disp_val2,
   input  logic              disp_q2_busy,
   input  logic [ROB_W-1:0]  disp_q2,
   input  logic [DATA_W-1:0] disp_imm,
   input  logic [ROB_W-1:0]  disp_rob_pos,
   input  logic [DATA_W-1:0] disp_pc,
   input  logic              alu_cdb_en,
   input  logic [ROB_W-1:0]  alu_cdb_pos,
   input  logic [DATA_W-1:0] alu_cdb_val,
   input  logic              lsb_cdb_en,
   input  logic [ROB_W-1:0]  lsb_cdb_pos,
   input  logic [DATA_W-1:0] lsb_cdb_val,
   output logic              full,
   output logic              alu_en,
   output logic [6:0]        alu_opcode,
   output logic [2:0]        alu_funct3,
   output logic              alu_funct7,
   output logic [DATA_W-1:0] alu_val1,
   output logic [DATA_W-1:0] alu_val2,
   output logic [DATA_W-1:0] alu_imm,
   output logic [ROB_W-1:0]  alu_rob_pos,
   output logic [DATA_W-1:0] alu_pc
);

   localparam int IDX_W = $clog2(RS_SIZE);

   logic [RS_SIZE-1:0] busy;
   logic [RS_SIZE-1:0] q1_busy;
   logic [RS_SIZE-1:0] q2_busy;
   logic [6:0]         e_opcode  [RS_SIZE];
   logic [2:0]         e_funct3  [RS_SIZE];
   logic               e_funct7  [RS_SIZE];
   logic [DATA_W-1:0]  e_val1    [RS_SIZE];
   logic [ROB_W-1:0]   e_q1      [RS_SIZE];
   logic [DATA_W-1:0]  e_val2    [RS_SIZE];
   logic [ROB_W-1:0]   e_q2      [RS_SIZE];
   logic [DATA_W-1:0]  e_imm     [RS_SIZE];
   logic [ROB_W-1:0]   e_rob_pos [RS_SIZE];
   logic [DATA_W-1:0]  e_pc      [RS_SIZE];

   logic [RS_SIZE-1:0] ready_vec;
   logic               free_found;
   logic [IDX_W-1:0]   free_idx;
   logic               ready_found;
   logic [IDX_W-1:0]   ready_idx;

   logic               d_q1_busy;
   logic [DATA_W-1:0]  d_val1;
   logic               d_q2_busy;
   logic [DATA_W-1:0]  d_val2;

   assign ready_vec = busy & ~q1_busy & ~q2_busy;
   assign full      = &busy;

   // Both searches look only at pre-edge state, so a slot freed by issue is not reused this cycle.
   always_comb begin
      free_found  = 1'b0;
      free_idx    = '0;
      ready_found = 1'b0;
      ready_idx   = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         if (!free_found && !busy[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
         if (!ready_found && ready_vec[i]) begin
            ready_found = 1'b1;
            ready_idx   = IDX_W'(i);
         end
      end
   end

   always_comb begin
      d_q1_busy = disp_q1_busy;
      d_val1    = disp_val1;
      d_q2_busy = disp_q2_busy;
      d_val2    = disp_val2;
      if (disp_q1_busy) begin
         if (alu_cdb_en && alu_cdb_pos == disp_q1) begin
            d_q1_busy = 1'b0;
            d_val1    = alu_cdb_val;
         end else if (lsb_cdb_en && lsb_cdb_pos == disp_q1) begin
            d_q1_busy = 1'b0;
            d_val1    = lsb_cdb_val;
         end
      end
      if (disp_q2_busy) begin
         if (alu_cdb_en && alu_cdb_pos == disp_q2) begin
            d_q2_busy = 1'b0;
            d_val2    = alu_cdb_val;
         end else if (lsb_cdb_en && lsb_cdb_pos == disp_q2) begin
            d_q2_busy = 1'b0;
            d_val2    = lsb_cdb_val;
         end
      end
   end

   // Wakeup touches only busy entries and dispatch only a free one, so their writes never collide.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy        <= '0;
         q1_busy     <= '0;
         q2_busy     <= '0;
         alu_en      <= 1'b0;
         alu_opcode  <= '0;
         alu_funct3  <= '0;
         alu_funct7  <= 1'b0;
         alu_val1    <= '0;
         alu_val2    <= '0;
         alu_imm     <= '0;
         alu_rob_pos <= '0;
         alu_pc      <= '0;
         for (int i = 0; i < RS_SIZE; i++) begin
            e_opcode[i]  <= '0;
            e_funct3[i]  <= '0;
            e_funct7[i]  <= 1'b0;
            e_val1[i]    <= '0;
            e_q1[i]      <= '0;
            e_val2[i]    <= '0;
            e_q2[i]      <= '0;
            e_imm[i]     <= '0;
            e_rob_pos[i] <= '0;
            e_pc[i]      <= '0;
         end
      end else if (!rdy) begin
         alu_en <= 1'b0;
      end else if (rollback) begin
         busy   <= '0;
         alu_en <= 1'b0;
      end else begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (busy[i] && q1_busy[i]) begin
               if (alu_cdb_en && alu_cdb_pos == e_q1[i]) begin
                  e_val1[i]  <= alu_cdb_val;
                  q1_busy[i] <= 1'b0;
               end else if (lsb_cdb_en && lsb_cdb_pos == e_q1[i]) begin
                  e_val1[i]  <= lsb_cdb_val;
                  q1_busy[i] <= 1'b0;
               end
            end
            if (busy[i] && q2_busy[i]) begin
               if (alu_cdb_en && alu_cdb_pos == e_q2[i]) begin
                  e_val2[i]  <= alu_cdb_val;
                  q2_busy[i] <= 1'b0;
               end else if (lsb_cdb_en && lsb_cdb_pos == e_q2[i]) begin
                  e_val2[i]  <= lsb_cdb_val;
                  q2_busy[i] <= 1'b0;
               end
            end
         end

         if (ready_found) begin
            alu_en          <= 1'b1;
            alu_opcode      <= e_opcode[ready_idx];
            alu_funct3      <= e_funct3[ready_idx];
            alu_funct7      <= e_funct7[ready_idx];
            alu_val1        <= e_val1[ready_idx];
            alu_val2        <= e_val2[ready_idx];
            alu_imm         <= e_imm[ready_idx];
            alu_rob_pos     <= e_rob_pos[ready_idx];
            alu_pc          <= e_pc[ready_idx];
            busy[ready_idx] <= 1'b0;
         end else begin
            alu_en <= 1'b0;
         end

         if (disp_en && !full) begin
            busy[free_idx]      <= 1'b1;
            q1_busy[free_idx]   <= d_q1_busy;
            q2_busy[free_idx]   <= d_q2_busy;
            e_opcode[free_idx]  <= disp_opcode;
            e_funct3[free_idx]  <= disp_funct3;
            e_funct7[free_idx]  <= disp_funct7;
            e_val1[free_idx]    <= d_val1;
            e_q1[free_idx]      <= disp_q1;
            e_val2[free_idx]    <= d_val2;
            e_q2[free_idx]      <= disp_q2;
            e_imm[free_idx]     <= disp_imm;
            e_rob_pos[free_idx] <= disp_rob_pos;
            e_pc[free_idx]      <= disp_pc;
         end
      end
   end

endmodule

// File: tb/tb_alu_rs_sched.sv
// Directed bench for alu_rs_sched: a vector table of independent ready ops plus
// hand-written sequences for wakeup, bypass, ordering/full, rollback, rdy and async reset.
module tb_alu_rs_sched;

   localparam int RS = 16;
   localparam int RW = 4;
   localparam int DW = 32;
   localparam logic [6:0] OP_ADD = 7'b0110011;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          rdy = 1'b1;
   logic          rollback = 1'b0;
   logic          disp_en = 1'b0;
   logic [6:0]    disp_opcode = '0;
   logic [2:0]    disp_funct3 = '0;
   logic          disp_funct7 = 1'b0;
   logic [DW-1:0] disp_val1 = '0;
   logic          disp_q1_busy = 1'b0;
   logic [RW-1:0] disp_q1 = '0;
   logic [DW-1:0] disp_val2 = '0;
   logic          disp_q2_busy = 1'b0;
   logic [RW-1:0] disp_q2 = '0;
   logic [DW-1:0] disp_imm = '0;
   logic [RW-1:0] disp_rob_pos = '0;
   logic [DW-1:0] disp_pc = '0;
   logic          alu_cdb_en = 1'b0;
   logic [RW-1:0] alu_cdb_pos = '0;
   logic [DW-1:0] alu_cdb_val = '0;
   logic          lsb_cdb_en = 1'b0;
   logic [RW-1:0] lsb_cdb_pos = '0;
   logic [DW-1:0] lsb_cdb_val = '0;
   logic          full;
   logic          alu_en;
   logic [6:0]    alu_opcode;
   logic [2:0]    alu_funct3;
   logic          alu_funct7;
   logic [DW-1:0] alu_val1;
   logic [DW-1:0] alu_val2;
   logic [DW-1:0] alu_imm;
   logic [RW-1:0] alu_rob_pos;
   logic [DW-1:0] alu_pc;

   int checks = 0;
   int failures = 0;

   alu_rs_sched #(.RS_SIZE(RS), .ROB_W(RW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
      .disp_en(disp_en), .disp_opcode(disp_opcode), .disp_funct3(disp_funct3),
      .disp_funct7(disp_funct7), .disp_val1(disp_val1), .disp_q1_busy(disp_q1_busy),
      .disp_q1(disp_q1), .disp_val2(disp_val2), .disp_q2_busy(disp_q2_busy),
      .disp_q2(disp_q2), .disp_imm(disp_imm), .disp_rob_pos(disp_rob_pos),
      .disp_pc(disp_pc), .alu_cdb_en(alu_cdb_en), .alu_cdb_pos(alu_cdb_pos),
      .alu_cdb_val(alu_cdb_val), .lsb_cdb_en(lsb_cdb_en), .lsb_cdb_pos(lsb_cdb_pos),
      .lsb_cdb_val(lsb_cdb_val), .full(full), .alu_en(alu_en), .alu_opcode(alu_opcode),
      .alu_funct3(alu_funct3), .alu_funct7(alu_funct7), .alu_val1(alu_val1),
      .alu_val2(alu_val2), .alu_imm(alu_imm), .alu_rob_pos(alu_rob_pos), .alu_pc(alu_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]    op;
      logic [2:0]    f3;
      logic          f7;
      logic [DW-1:0] v1;
      logic [DW-1:0] v2;
      logic [DW-1:0] imm;
      logic [RW-1:0] rob;
      logic [DW-1:0] pc;
      logic [6:0]    exp_op;
      logic [2:0]    exp_f3;
      logic          exp_f7;
      logic [DW-1:0] exp_v1;
      logic [DW-1:0] exp_v2;
      logic [DW-1:0] exp_imm;
      logic [RW-1:0] exp_rob;
      logic [DW-1:0] exp_pc;
   } vec_t;

   vec_t vecs[4];

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clearInputs();
      disp_en      = 1'b0;
      disp_q1_busy = 1'b0;
      disp_q2_busy = 1'b0;
      alu_cdb_en   = 1'b0;
      lsb_cdb_en   = 1'b0;
   endtask

   task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                input logic [DW-1:0] v1, input logic q1b, input logic [RW-1:0] q1,
                                input logic [DW-1:0] v2, input logic q2b, input logic [RW-1:0] q2,
                                input logic [DW-1:0] imm, input logic [RW-1:0] rob,
                                input logic [DW-1:0] pc);
      disp_en      = 1'b1;
      disp_opcode  = op;
      disp_funct3  = f3;
      disp_funct7  = f7;
      disp_val1    = v1;
      disp_q1_busy = q1b;
      disp_q1      = q1;
      disp_val2    = v2;
      disp_q2_busy = q2b;
      disp_q2      = q2;
      disp_imm     = imm;
      disp_rob_pos = rob;
      disp_pc      = pc;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired actual=running required=finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      vecs[0] = '{OP_ADD, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 4'd3, 32'h1000,
                  OP_ADD, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 4'd3, 32'h1000};
      vecs[1] = '{OP_ADD, 3'd0, 1'b1, 32'hFFFF_FFFF, 32'h1, 32'd0, 4'd14, 32'h1004,
                  OP_ADD, 3'd0, 1'b1, 32'hFFFF_FFFF, 32'h1, 32'd0, 4'd14, 32'h1004};
      vecs[2] = '{7'b0010011, 3'd7, 1'b0, 32'hA5A5_0000, 32'd0, 32'h0000_0FFF, 4'd0, 32'h2000,
                  7'b0010011, 3'd7, 1'b0, 32'hA5A5_0000, 32'd0, 32'h0000_0FFF, 4'd0, 32'h2000};
      vecs[3] = '{7'b1100011, 3'd1, 1'b0, 32'd42, 32'd43, 32'hFFFF_FFF0, 4'd15, 32'hFFFF_FFFC,
                  7'b1100011, 3'd1, 1'b0, 32'd42, 32'd43, 32'hFFFF_FFF0, 4'd15, 32'hFFFF_FFFC};

      // Reset and idle
      step();
      step();
      checkOutput("reset_alu_en", 64'(alu_en), 64'd0);
      checkOutput("reset_full", 64'(full), 64'd0);
      checkOutput("reset_opcode", 64'(alu_opcode), 64'd0);
      checkOutput("reset_val1", 64'(alu_val1), 64'd0);
      checkOutput("reset_rob_pos", 64'(alu_rob_pos), 64'd0);
      checkOutput("reset_pc", 64'(alu_pc), 64'd0);
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         checkOutput("idle_alu_en", 64'(alu_en), 64'd0);
      end

      // Table of independent ready ops: issue one cycle after dispatch, payload holds after
      for (int v = 0; v < 4; v++) begin
         applyStimulus(vecs[v].op, vecs[v].f3, vecs[v].f7, vecs[v].v1, 1'b0, 4'd0,
                       vecs[v].v2, 1'b0, 4'd0, vecs[v].imm, vecs[v].rob, vecs[v].pc);
         step();
         clearInputs();
         checkOutput("vec_no_early_issue", 64'(alu_en), 64'd0);
         step();
         checkOutput("vec_alu_en", 64'(alu_en), 64'd1);
         checkOutput("vec_opcode", 64'(alu_opcode), 64'(vecs[v].exp_op));
         checkOutput("vec_funct3", 64'(alu_funct3), 64'(vecs[v].exp_f3));
         checkOutput("vec_funct7", 64'(alu_funct7), 64'(vecs[v].exp_f7));
         checkOutput("vec_val1", 64'(alu_val1), 64'(vecs[v].exp_v1));
         checkOutput("vec_val2", 64'(alu_val2), 64'(vecs[v].exp_v2));
         checkOutput("vec_imm", 64'(alu_imm), 64'(vecs[v].exp_imm));
         checkOutput("vec_rob_pos", 64'(alu_rob_pos), 64'(vecs[v].exp_rob));
         checkOutput("vec_pc", 64'(alu_pc), 64'(vecs[v].exp_pc));
         step();
         checkOutput("vec_alu_en_drop", 64'(alu_en), 64'd0);
         checkOutput("vec_payload_hold", 64'(alu_val1), 64'(vecs[v].exp_v1));
      end

      // Wakeup from LSB CDB three cycles after dispatch; a non-matching ALU tag must not wake
      applyStimulus(OP_ADD, 3'd0, 1'b0, 32'd0, 1'b1, 4'd9, 32'd2, 1'b0, 4'd0, 32'd0, 4'd5, 32'h3000);
      step();
      clearInputs();
      step();
      alu_cdb_en  = 1'b1;
      alu_cdb_pos = 4'd8;
      alu_cdb_val = 32'hBAD;
      checkOutput("wake_wait1", 64'(alu_en), 64'd0);
      step();
      clearInputs();
      checkOutput("wake_wait2", 64'(alu_en), 64'd0);
      lsb_cdb_en  = 1'b1;
      lsb_cdb_pos = 4'd9;
      lsb_cdb_val = 32'h100;
      step();
      clearInputs();
      checkOutput("wake_wait3", 64'(alu_en), 64'd0);
      step();
      checkOutput("wake_alu_en", 64'(alu_en), 64'd1);
      checkOutput("wake_val1", 64'(alu_val1), 64'h100);
      checkOutput("wake_val2", 64'(alu_val2), 64'd2);
      checkOutput("wake_rob_pos", 64'(alu_rob_pos), 64'd5);
      step();
      checkOutput("wake_drop", 64'(alu_en), 64'd0);

      // Same-cycle bypass: rs1 from the ALU CDB, rs2 from the LSB CDB
      applyStimulus(OP_ADD, 3'd0, 1'b0, 32'd0, 1'b1, 4'd9, 32'd0, 1'b1, 4'd10, 32'd0, 4'd6, 32'h3004);
      alu_cdb_en  = 1'b1;
      alu_cdb_pos = 4'd9;
      alu_cdb_val = 32'h55;
      lsb_cdb_en  = 1'b1;
      lsb_cdb_pos = 4'd10;
      lsb_cdb_val = 32'h77;
      step();
      clearInputs();
      checkOutput("bypass_no_early", 64'(alu_en), 64'd0);
      step();
      checkOutput("bypass_alu_en", 64'(alu_en), 64'd1);
      checkOutput("bypass_val1", 64'(alu_val1), 64'h55);
      checkOutput("bypass_val2", 64'(alu_val2), 64'h77);
      checkOutput("bypass_rob_pos", 64'(alu_rob_pos), 64'd6);
      step();

      // Fill all entries pending on tag 1, then broadcast and watch in-order drain
      for (int i = 0; i < RS; i++) begin
         checkOutput("fill_not_full", 64'(full), 64'd0);
         applyStimulus(OP_ADD, 3'd0, 1'b0, 32'd0, 1'b1, 4'd1, 32'(i), 1'b0, 4'd0, 32'd0, 4'(i), 32'h4000);
         step();
      end
      clearInputs();
      checkOutput("fill_full", 64'(full), 64'd1);
      applyStimulus(OP_ADD, 3'd0, 1'b0, 32'hDEAD, 1'b0, 4'd0, 32'hBEEF, 1'b0, 4'd0, 32'd0, 4'd12, 32'h5000);
      step();
      clearInputs();
      checkOutput("overflow_full", 64'(full), 64'd1);
      step();
      checkOutput("overflow_ignored", 64'(alu_en), 64'd0);
      alu_cdb_en  = 1'b1;
      alu_cdb_pos = 4'd1;
      alu_cdb_val = 32'h1000;
      step();
      clearInputs();
      checkOutput("drain_wake_no_issue", 64'(alu_en), 64'd0);
      checkOutput("drain_still_full", 64'(full), 64'd1);
      for (int i = 0; i < RS; i++) begin
         step();
         checkOutput("drain_alu_en", 64'(alu_en), 64'd1);
         checkOutput("drain_rob_pos", 64'(alu_rob_pos), 64'(i));
         checkOutput("drain_val2", 64'(alu_val2), 64'(i));
         checkOutput("drain_val1", 64'(alu_val1), 64'h1000);
         if (i == 0) checkOutput("drain_full_drop", 64'(full), 64'd0);
      end
      step();
      checkOutput("drain_done", 64'(alu_en), 64'd0);
      checkOutput("drain_empty_full", 64'(full), 64'd0);

      // Rollback while one op issues and another is ready, four pending on tag 3
      for (int i = 0; i < 4; i++) begin
         applyStimulus(OP_ADD, 3'd0, 1'b0, 32'd0, 1'b1, 4'd3, 32'd0, 1'b0, 4'd0, 32'd0, 4'(4 + i), 32'h6000);
         step();
      end
      applyStimulus(OP_ADD, 3'd0, 1'b0, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd0, 4'd2, 32'h6010);
      step();
      applyStimulus(OP_ADD, 3'd0, 1'b0, 32'd2, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0, 32'd0, 4'd8, 32'h6014);
      step();
      clearInputs();
      checkOutput("rb_issue_before", 64'(alu_en), 64'd1);
      checkOutput("rb_issue_rob", 64'(alu_rob_pos), 64'd2);
      rollback = 1'b1;
      step();
      rollback = 1'b0;
      checkOutput("rb_alu_en", 64'(alu_en), 64'd0);
      checkOutput("rb_full", 64'(full), 64'd0);
      alu_cdb_en  = 1'b1;
      alu_cdb_pos = 4'd3;
      alu_cdb_val = 32'h33;
      step();
      clearInputs();
      checkOutput("rb_stale1", 64'(alu_en), 64'd0);
      step();
      checkOutput("rb_stale2", 64'(alu_en), 64'd0);
      step();
      checkOutput("rb_stale3", 64'(alu_en), 64'd0);

      // rdy low freezes a ready entry and ignores dispatch
      applyStimulus(OP_ADD, 3'd0, 1'b0, 32'd11, 1'b0, 4'd0, 32'd11, 1'b0, 4'd0, 32'd0, 4'd11, 32'h7000);
      step();
      clearInputs();
      rdy = 1'b0;
      applyStimulus(OP_ADD, 3'd0, 1'b0, 32'd12, 1'b0, 4'd0, 32'd12, 1'b0, 4'd0, 32'd0, 4'd12, 32'h7004);
      for (int i = 0; i < 3; i++) begin
         step();
         checkOutput("rdy_frozen", 64'(alu_en), 64'd0);
      end
      clearInputs();
      rdy = 1'b1;
      step();
      checkOutput("rdy_issue", 64'(alu_en), 64'd1);
      checkOutput("rdy_issue_rob", 64'(alu_rob_pos), 64'd11);
      step();
      checkOutput("rdy_dispatch_ignored", 64'(alu_en), 64'd0);

      // Asynchronous reset between edges while alu_en is high
      applyStimulus(OP_ADD, 3'd0, 1'b0, 32'd13, 1'b0, 4'd0, 32'd13, 1'b0, 4'd0, 32'd0, 4'd13, 32'h8000);
      step();
      clearInputs();
      step();
      checkOutput("areset_pre", 64'(alu_en), 64'd1);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("areset_alu_en", 64'(alu_en), 64'd0);
      checkOutput("areset_rob_pos", 64'(alu_rob_pos), 64'd0);
      checkOutput("areset_full", 64'(full), 64'd0);
      step();
      rst = 1'b1;
      step();
      checkOutput("areset_after", 64'(alu_en), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
